// File: rtl/amm_slave_mem_if.sv
// rtl/amm_slave_mem_if.sv - Avalon-MM burst command/response bus for amm_slave_mem
// Signal suffixes are from the slave's point of view.
interface amm_slave_mem_if #(
   parameter int AMM_ADDR_W  = 31,
   parameter int AMM_DATA_W  = 128,
   parameter int AMM_BURST_W = 11,
   parameter int DATA_B_W    = AMM_DATA_W / 8
);
   logic [AMM_ADDR_W-1:0]  address_i;
   logic                   read_i;
   logic                   write_i;
   logic [AMM_DATA_W-1:0]  writedata_i;
   logic [AMM_BURST_W-1:0] burstcount_i;
   logic [DATA_B_W-1:0]    byteenable_i;
   logic                   waitrequest_o;
   logic [AMM_DATA_W-1:0]  readdata_o;
   logic                   readdatavalid_o;

   modport slave (
      input  address_i, read_i, write_i, writedata_i, burstcount_i, byteenable_i,
      output waitrequest_o, readdata_o, readdatavalid_o
   );

   modport master (
      output address_i, read_i, write_i, writedata_i, burstcount_i, byteenable_i,
      input  waitrequest_o, readdata_o, readdatavalid_o
   );
endinterface

// File: rtl/amm_slave_mem.sv
// rtl/amm_slave_mem.sv - Avalon-MM burst slave backed by an on-chip word array
// Fixed-latency burst reads, byte-masked burst writes, optional periodic stalls.
module amm_slave_mem #(
   parameter int    AMM_ADDR_W   = 31,
   parameter int    AMM_DATA_W   = 128,
   parameter int    AMM_BURST_W  = 11,
   parameter int    DATA_B_W     = AMM_DATA_W / 8,
   parameter string ADDR_TYPE    = "BYTE",
   parameter int    MEM_ADDR_W   = 10,
   parameter int    READ_LATENCY = 2,
   parameter int    STALL_PERIOD = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   amm_slave_mem_if.slave    amm,
   output logic              protocol_err_o,
   output logic [31:0]       wr_beats_o,
   output logic [31:0]       rd_beats_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;

   localparam bit BYTE_ADDR = (ADDR_TYPE == "BYTE");
   localparam int BYTE_SH   = $clog2(DATA_B_W);
   localparam int STALL_W   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   localparam logic [STALL_W-1:0]     STALL_LAST = STALL_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
   localparam logic [STALL_W-1:0]     STALL_ONE  = STALL_W'(1);
   localparam logic [MEM_ADDR_W-1:0]  IDX_ONE    = MEM_ADDR_W'(1);
   localparam logic [AMM_BURST_W-1:0] BC_ONE     = AMM_BURST_W'(1);

   logic [AMM_DATA_W-1:0]  mem_q [2**MEM_ADDR_W];

   logic [1:0]             state_q, state_d;
   logic [MEM_ADDR_W-1:0]  idx_q, idx_d;
   logic [AMM_BURST_W-1:0] rem_q, rem_d;
   logic [AMM_BURST_W-1:0] iss_rem_q, iss_rem_d;
   logic [AMM_BURST_W-1:0] out_rem_q, out_rem_d;
   logic                   err_q, err_d;
   logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [31:0]            wr_beats_q, wr_beats_d;
   logic [31:0]            rd_beats_q, rd_beats_d;
   logic                   rvalid_q;
   logic [AMM_DATA_W-1:0]  rdata_q;

   logic                   stall;
   logic                   waitreq;
   logic                   accept;
   logic [AMM_ADDR_W-1:0]  word_addr;
   logic [MEM_ADDR_W-1:0]  cmd_idx;
   logic [AMM_BURST_W-1:0] cmd_burst;
   logic                   wr_en;
   logic [MEM_ADDR_W-1:0]  wr_addr;
   logic                   issue_vld;
   logic [MEM_ADDR_W-1:0]  issue_addr;
   logic                   fin_vld;
   logic [MEM_ADDR_W-1:0]  fin_addr;
   logic                   unused_addr_bits;

   assign stall   = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
   assign waitreq = !rst_n_i || (state_q == S_RD) || stall;
   assign accept  = (amm.read_i || amm.write_i) && !waitreq;

   assign word_addr        = BYTE_ADDR ? (amm.address_i >> BYTE_SH) : amm.address_i;
   assign cmd_idx          = word_addr[MEM_ADDR_W-1:0];
   assign unused_addr_bits = ^word_addr[AMM_ADDR_W-1:MEM_ADDR_W];
   // A zero burstcount is a protocol error but is still serviced as one beat.
   assign cmd_burst        = (amm.burstcount_i == '0) ? BC_ONE : amm.burstcount_i;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      iss_rem_d  = iss_rem_q;
      out_rem_d  = out_rem_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_addr    = idx_q;
      issue_vld  = 1'b0;
      issue_addr = idx_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (amm.burstcount_i == '0) err_d = 1'b1;
               idx_d = cmd_idx + IDX_ONE;
               if (amm.read_i) begin
                  if (amm.write_i) err_d = 1'b1;
                  issue_vld  = 1'b1;
                  issue_addr = cmd_idx;
                  iss_rem_d  = cmd_burst - BC_ONE;
                  out_rem_d  = cmd_burst;
                  state_d    = S_RD;
               end else begin
                  wr_en   = 1'b1;
                  wr_addr = cmd_idx;
                  rem_d   = cmd_burst - BC_ONE;
                  if (cmd_burst != BC_ONE) state_d = S_WR;
               end
            end
         end
         S_WR: begin
            if (amm.read_i) err_d = 1'b1;
            if (amm.write_i && !waitreq) begin
               wr_en = 1'b1;
               idx_d = idx_q + IDX_ONE;
               rem_d = rem_q - BC_ONE;
               if (rem_q == BC_ONE) state_d = S_IDLE;
            end
         end
         S_RD: begin
            // Issue side runs ahead of the output side by READ_LATENCY cycles.
            if (iss_rem_q != '0) begin
               issue_vld = 1'b1;
               idx_d     = idx_q + IDX_ONE;
               iss_rem_d = iss_rem_q - BC_ONE;
            end
            if (rvalid_q) begin
               out_rem_d = out_rem_q - BC_ONE;
               if (out_rem_q == BC_ONE) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall_cnt_d = (STALL_PERIOD == 0 || stall) ? '0 : stall_cnt_q + STALL_ONE;
   assign wr_beats_d  = wr_beats_q + 32'(wr_en);
   assign rd_beats_d  = rd_beats_q + 32'(rvalid_q);

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign fin_vld  = issue_vld;
         assign fin_addr = issue_addr;
      end else begin : g_pipe
         logic [READ_LATENCY-2:0] vld_q;
         logic [MEM_ADDR_W-1:0]   addr_q [READ_LATENCY-1];

         always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= issue_vld;
               for (int s = 1; s < READ_LATENCY - 1; s++) vld_q[s] <= vld_q[s-1];
            end
         end

         always_ff @(posedge clk_i) begin
            addr_q[0] <= issue_addr;
            for (int s = 1; s < READ_LATENCY - 1; s++) addr_q[s] <= addr_q[s-1];
         end

         assign fin_vld  = vld_q[READ_LATENCY-2];
         assign fin_addr = addr_q[READ_LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < DATA_B_W; b++) begin
            if (amm.byteenable_i[b]) mem_q[wr_addr][8*b +: 8] <= amm.writedata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         iss_rem_q   <= '0;
         out_rem_q   <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         wr_beats_q  <= '0;
         rd_beats_q  <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         iss_rem_q   <= iss_rem_d;
         out_rem_q   <= out_rem_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         wr_beats_q  <= wr_beats_d;
         rd_beats_q  <= rd_beats_d;
         rvalid_q    <= fin_vld;
         if (fin_vld) rdata_q <= mem_q[fin_addr];
      end
   end

   assign amm.waitrequest_o   = waitreq;
   assign amm.readdata_o      = rdata_q;
   assign amm.readdatavalid_o = rvalid_q;
   assign protocol_err_o      = err_q;
   assign wr_beats_o          = wr_beats_q;
   assign rd_beats_o          = rd_beats_q;

endmodule

// File: tb/tb_amm_slave_mem.sv
// tb/tb_amm_slave_mem.sv - directed + randomized bench for amm_slave_mem
// 16-word memory, 128-bit data, byte addressing, latency 2, stall every 3rd cycle.
module tb_amm_slave_mem;

   localparam int P     = 3;
   localparam int WORDS = 16;

   logic        clk;
   logic        rst_n;
   logic        perr;
   logic [31:0] wrb;
   logic [31:0] rdb;

   int total = 0;
   int bad   = 0;
   int exp_wr;
   int exp_rd;
   logic exp_perr;
   int kcyc;

   logic [127:0] ref_mem [WORDS];
   logic [127:0] wbuf [16];
   logic [127:0] last_rd;

   amm_slave_mem_if #(.AMM_ADDR_W(31), .AMM_DATA_W(128), .AMM_BURST_W(11)) bus ();

   amm_slave_mem #(
      .AMM_ADDR_W(31), .AMM_DATA_W(128), .AMM_BURST_W(11), .ADDR_TYPE("BYTE"),
      .MEM_ADDR_W(4), .READ_LATENCY(2), .STALL_PERIOD(P)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .amm(bus),
      .protocol_err_o(perr), .wr_beats_o(wrb), .rd_beats_o(rdb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles elapsed since reset release; the slave stalls on every P-th such cycle.
   always @(posedge clk) begin
      if (!rst_n) kcyc <= 0;
      else        kcyc <= kcyc + 1;
   end

   function automatic logic stall_exp();
      return ((kcyc % P) == P - 1);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      chk("wr_beats", wrb, exp_wr);
      chk("rd_beats", rdb, exp_rd);
      chk("protocol_err", perr, exp_perr);
   endtask

   task automatic model_write(input int w, input logic [127:0] d, input logic [15:0] be);
      for (int b = 0; b < 16; b++) if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic do_write(input int w0, input int n, input logic [15:0] be, input bit gaps);
      int  beat  = 0;
      int  guard = 0;
      logic acc;
      bus.write_i      = 1'b1;
      bus.read_i       = 1'b0;
      bus.address_i    = 31'(w0 * 16);
      bus.burstcount_i = 11'(n);
      bus.byteenable_i = be;
      bus.writedata_i  = wbuf[0];
      while (beat < n && guard < 200) begin
         @(negedge clk);
         chk("wr_wait", bus.waitrequest_o, stall_exp());
         acc = (bus.write_i && !bus.waitrequest_o);
         @(posedge clk); #1;
         guard++;
         if (acc) begin
            model_write((w0 + beat) % WORDS, wbuf[beat], be);
            exp_wr++;
            beat++;
            bus.address_i    = 31'($urandom);
            bus.burstcount_i = 11'($urandom);
            if (beat < n) bus.writedata_i = wbuf[beat];
            bus.write_i = !(gaps && beat < n && ($urandom % 2 == 1));
         end else begin
            bus.write_i = 1'b1;
         end
      end
      chk("wr_beats_done", beat, n);
      bus.write_i = 1'b0;
      chk_status();
   endtask

   task automatic do_read(input int w0, input int bc, input bit both);
      int   n     = (bc == 0) ? 1 : bc;
      int   guard = 0;
      logic acc   = 1'b0;
      logic exp_v;
      bus.read_i       = 1'b1;
      bus.write_i      = both;
      bus.writedata_i  = rnd128();
      bus.byteenable_i = '1;
      bus.address_i    = 31'(w0 * 16);
      bus.burstcount_i = 11'(bc);
      while (!acc && guard < 20) begin
         @(negedge clk);
         chk("rd_cmd_wait", bus.waitrequest_o, stall_exp());
         acc = !bus.waitrequest_o;
         @(posedge clk); #1;
         guard++;
      end
      chk("rd_accept", acc, 1'b1);
      if (both || bc == 0) exp_perr = 1'b1;
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      for (int j = 1; j <= n + 2; j++) begin
         @(negedge clk);
         exp_v = (j >= 2 && j <= n + 1);
         chk("rd_valid", bus.readdatavalid_o, exp_v);
         if (exp_v) begin
            chk("rd_data", bus.readdata_o, ref_mem[(w0 + j - 2) % WORDS]);
            last_rd = bus.readdata_o;
            exp_rd++;
         end
         if (j <= n + 1) chk("rd_wait_hi", bus.waitrequest_o, 1'b1);
         else            chk("rd_wait_end", bus.waitrequest_o, stall_exp());
         @(posedge clk); #1;
      end
      chk_status();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   guard;
      bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = '0;
      bus.writedata_i = '0; bus.burstcount_i = '0; bus.byteenable_i = '0;
      exp_wr = 0; exp_rd = 0; exp_perr = 1'b0; last_rd = '0;
      rst_n = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wait", bus.waitrequest_o, 1'b1);
      chk("rst_valid", bus.readdatavalid_o, 1'b0);
      chk("rst_rdata", bus.readdata_o, 128'd0);
      chk_status();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_wait", bus.waitrequest_o, 1'b0);
      @(posedge clk); #1;

      // Single write then read at byte address 0x40 (word 4).
      wbuf[0] = {16{8'hA5}};
      do_write(4, 1, 16'hFFFF, 1'b0);
      do_read(4, 1, 1'b0);
      chk("single_a5", last_rd, {16{8'hA5}});

      // Byte-enable masking on word 5.
      wbuf[0] = '0;
      do_write(5, 1, 16'hFFFF, 1'b0);
      wbuf[0] = '1;
      do_write(5, 1, 16'h000F, 1'b0);
      do_read(5, 1, 1'b0);
      chk("be_mask", last_rd, {96'd0, 32'hFFFF_FFFF});

      // Burst of 8 with stalls, write_i held.
      for (int i = 0; i < 8; i++) wbuf[i] = 128'(i + 1) * 128'h0101_0101_0101_0101_0101_0101_0101_0101;
      do_write(6, 8, 16'hFFFF, 1'b0);
      do_read(6, 8, 1'b0);

      // Wrap-around: words 14,15,0,1.
      for (int i = 0; i < 4; i++) wbuf[i] = rnd128();
      do_write(14, 4, 16'hFFFF, 1'b0);
      do_read(0, 2, 1'b0);
      chk("wrap_beat3", last_rd, wbuf[3]);

      for (int i = 0; i < 2; i++) wbuf[i] = rnd128();
      do_write(2, 2, 16'hFFFF, 1'b0);

      // Randomized bursts with gaps, random byte enables and random reads.
      for (int it = 0; it < 8; it++) begin
         int w0, n, r0, rn;
         w0 = $urandom % WORDS;
         n  = 1 + $urandom % 6;
         for (int i = 0; i < n; i++) wbuf[i] = rnd128();
         do_write(w0, n, 16'($urandom), 1'b1);
         repeat ($urandom % 3) @(posedge clk);
         #1;
         r0 = $urandom % WORDS;
         rn = 1 + $urandom % 9;
         do_read(r0, rn, 1'b0);
      end

      // Protocol errors: read+write together, and zero burstcount.
      chk("perr_before", perr, 1'b0);
      do_read(3, 1, 1'b1);
      do_read(9, 0, 1'b0);
      wbuf[0] = rnd128();
      do_write(10, 1, 16'hFFFF, 1'b0);
      do_read(10, 1, 1'b0);
      chk("perr_sticky", perr, 1'b1);

      // Reset one cycle after a burst-16 read is accepted.
      bus.read_i = 1'b1; bus.address_i = '0; bus.burstcount_i = 11'd16;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 20) begin
         @(negedge clk);
         acc = !bus.waitrequest_o;
         @(posedge clk); #1;
         guard++;
      end
      chk("rst_rd_accept", acc, 1'b1);
      bus.read_i = 1'b0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_valid", bus.readdatavalid_o, 1'b0);
         chk("midrst_wait", bus.waitrequest_o, 1'b1);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      exp_wr = 0; exp_rd = 0; exp_perr = 1'b0;
      @(negedge clk);
      chk("rel_wait", bus.waitrequest_o, 1'b0);
      chk("rel_rdata", bus.readdata_o, 128'd0);
      @(posedge clk); #1;
      repeat (20) begin
         @(negedge clk);
         chk("after_valid", bus.readdatavalid_o, 1'b0);
         chk("after_wait", bus.waitrequest_o, stall_exp());
         @(posedge clk); #1;
      end
      chk_status();
      do_read(6, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/amm_slave_mem.md
Name: amm_slave_mem

Overview:
- Synthesizable Avalon-MM burst slave backed by an on-chip word array.
- It is the responder end of the AMM master interface driven by the checker's transmitter. It accepts burst writes with byteenable and burst reads, then returns read data with a fixed latency.
- Used as the loopback target for mem_checker self-test on FPGA and as the DUT-side model in block benches.
- Optional periodic waitrequest stalls exercise master back-pressure handling.

Parameters:
- AMM_ADDR_W, 31: width of address_i.
- AMM_DATA_W, 128: data width. Must be a power of 2 and ≥ 8.
- AMM_BURST_W, 11: width of burstcount_i.
- DATA_B_W, AMM_DATA_W/8: number of byte lanes.
- ADDR_TYPE, "BYTE": "BYTE" means address_i is a byte address, and the word index is address_i >> log2(DATA_B_W). "WORD" means address_i is a word index.
- MEM_ADDR_W, 10: log2 of memory depth in words.
- READ_LATENCY, 2: cycles from read command acceptance to first readdatavalid_o. Legal range 1..8.
- STALL_PERIOD, 0: if nonzero, waitrequest_o is forced high for 1 cycle in every STALL_PERIOD cycles.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- address_i  in  AMM_ADDR_W  command address
- read_i  in  1  read request
- write_i  in  1  write request / write beat
- writedata_i  in  AMM_DATA_W  write data
- burstcount_i  in  AMM_BURST_W  beats in burst
- byteenable_i  in  DATA_B_W  byte lane enables for the write beat
- waitrequest_o  out  1  back-pressure
- readdata_o  out  AMM_DATA_W  read data
- readdatavalid_o  out  1  read data valid
- protocol_err_o  out  1  sticky protocol violation flag
- wr_beats_o  out  32  count of accepted write beats (wraps)
- rd_beats_o  out  32  count of returned read beats (wraps)

Behaviour:
- Reset: synchronous, sampled on clk_i rising edge while rst_n_i=0.
  - Reset values: state=IDLE, waitrequest_o=1, readdatavalid_o=0, readdata_o=0, protocol_err_o=0, wr_beats_o=0, rd_beats_o=0, stall counter=0.
  - Memory array contents are not reset.
  - Reset mid-burst aborts the burst; no further readdatavalid_o pulses follow.
- waitrequest_o is combinational: high when rst_n_i=0, when state=RD, or in a stall cycle; low otherwise.
- Stall timing: the stall counter counts 0..STALL_PERIOD-1 and stalls when it equals STALL_PERIOD-1. With STALL_PERIOD=0 it never stalls.
- Beat acceptance: a beat or command is accepted when (read_i | write_i) & !waitrequest_o.
- State machine: IDLE, WR, RD.
- IDLE:
  - Accepted write: latch word index, latch burstcount_i into the remaining counter, and store beat 0 using byteenable_i (only enabled bytes are updated).
    - burstcount_i=1: stay in IDLE.
    - Otherwise: go to WR with remaining = burstcount_i-1 and next index = idx+1.
  - Accepted read: latch index and burstcount_i, then go to RD.
  - read_i and write_i both high: set protocol_err_o and treat the command as a read.
  - burstcount_i=0: set protocol_err_o and treat as 1.
- WR:
  - Each cycle with write_i & !waitrequest_o stores one beat at the next index, increments the index, and decrements remaining.
  - Return to IDLE on the beat that takes remaining to 0.
  - read_i asserted in WR: set protocol_err_o and ignore it.
  - address_i and burstcount_i are ignored in WR.
  - Write gaps (write_i=0) are allowed.
- RD:
  - waitrequest_o is held high.
  - The read pipeline returns beats on consecutive cycles with no gaps. The first beat is presented on cycle T+READ_LATENCY, where T is the accept cycle.
  - readdata_o = mem[idx+k] for beat k.
  - Return to IDLE in the cycle after the last beat. waitrequest_o may drop in that cycle.
  - Read data and readdatavalid_o are registered outputs.
- Address arithmetic: the word index is truncated to MEM_ADDR_W bits. Bursts wrap modulo 2^MEM_ADDR_W.
- Beat counters:
  - wr_beats_o increments per stored beat.
  - rd_beats_o increments per readdatavalid_o cycle.
  - Both are 32-bit and wrap.
- protocol_err_o clears only on reset.

Test Plan:
- Single write then read: BYTE mode, DATA_B_W=16. Write addr 0x40, burst 1, data all 0xA5, byteenable all 1s. Read addr 0x40 → at T+2 readdatavalid_o=1 for 1 cycle, readdata_o all 0xA5. rd_beats_o=1, wr_beats_o=1.
- Byteenable masking: write 0x00 to all lanes, then write 0xFF with byteenable=0x000F. Read back → low 4 bytes 0xFF, rest 0x00.
- Burst with stalls: STALL_PERIOD=3. Write burst of 8 incrementing words with write_i held → exactly 8 beats stored, and no beat is accepted in stall cycles. Read burst 8 → 8 consecutive valid beats with matching data. waitrequest_o is high throughout RD.
- Wrap-around: MEM_ADDR_W=4. Write burst 4 at word 14 → words 14,15,0,1 are written. Read at word 0, burst 2 → data of beats 2 and 3.
- Protocol errors: read_i and write_i both high in IDLE → protocol_err_o=1 and a read is performed. Also burstcount_i=0 → 1 beat and protocol_err_o=1. protocol_err_o stays 1 until reset.
- Reset mid-read: reset asserted 1 cycle after a burst-16 read is accepted → readdatavalid_o=0 from then on. After release, waitrequest_o=0 and the state is IDLE.
